// File: rtl/register_dump_tx.sv
// register_dump_tx: debug read-out sequencer for the register file.
// Walks addresses 0..NREG-1 through a registered read port and streams each
// 32-bit word MSB-first as bytes over a valid/ready interface, optionally
// preceded by a single header byte. All outputs are registered.
module register_dump_tx #(
    parameter int         NREG        = 32,
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter bit         SEND_HEADER = 1'b1
) (
    input  logic        clk,
    input  logic        inicio,
    input  logic        start,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        REQ  = 3'd2,
        CAP  = 3'd3,
        SEND = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NREG - 1);

    state_t      state, state_next;
    logic [4:0]  index, index_next;
    logic [1:0]  count, count_next;
    logic [31:0] shift, shift_next;
    logic [4:0]  rf_addr_next;
    logic [7:0]  tx_data_next;
    logic        tx_valid_next;
    logic        busy_next;
    logic        done_next;

    // Next-state logic plus the next value of every registered output, so the
    // outputs change on the same edge the state does.
    always_comb begin
        state_next = state;
        index_next = index;
        count_next = count;
        shift_next = shift;

        case (state)
            IDLE: begin
                if (start) begin
                    index_next = 5'd0;
                    state_next = SEND_HEADER ? HDR : REQ;
                end
            end
            HDR: begin
                if (tx_ready) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                state_next = CAP;
            end
            CAP: begin
                // The read port delivers the word addressed in REQ by this edge.
                shift_next = rf_data;
                count_next = 2'd0;
                state_next = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    shift_next = {shift[23:0], 8'h00};
                    count_next = 2'(count + 2'd1);
                    if (count == 2'd3) begin
                        if (index == LAST_IDX) begin
                            state_next = DONE;
                        end else begin
                            index_next = 5'(index + 5'd1);
                            state_next = REQ;
                        end
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // rf_addr only moves when entering REQ; it holds everywhere else.
        rf_addr_next = (state_next == REQ) ? index_next : rf_addr;

        // tx_data only changes when a new byte is presented; while stalled the
        // shift register holds, so the same byte is re-presented.
        case (state_next)
            HDR:     tx_data_next = HEADER;
            SEND:    tx_data_next = shift_next[31:24];
            default: tx_data_next = tx_data;
        endcase

        tx_valid_next = (state_next == HDR) || (state_next == SEND);
        busy_next     = (state_next != IDLE);
        done_next     = (state_next == DONE);
    end

    // Control state and registered outputs, cleared immediately on inicio.
    always_ff @(posedge clk or posedge inicio) begin
        if (inicio) begin
            state    <= IDLE;
            index    <= 5'd0;
            count    <= 2'd0;
            rf_addr  <= 5'd0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            index    <= index_next;
            count    <= count_next;
            rf_addr  <= rf_addr_next;
            tx_data  <= tx_data_next;
            tx_valid <= tx_valid_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

    // Word shift register: pure data, always reloaded in CAP before use.
    always_ff @(posedge clk) begin
        shift <= shift_next;
    end

endmodule

// File: tb/tb_register_dump_tx.sv
// Directed self-checking bench for register_dump_tx: a default instance
// (header, 32 registers) and a small instance (no header, 4 registers).
module tb_register_dump_tx;

    logic        clk;
    logic        inicio;
    logic        start, start2;
    logic        tx_ready, tx_ready2;
    logic [31:0] rf_data, rf_data2;
    logic [4:0]  rf_addr, rf_addr2;
    logic [7:0]  tx_data, tx_data2;
    logic        tx_valid, tx_valid2;
    logic        busy, busy2;
    logic        done, done2;

    int passed = 0;
    int total  = 0;

    logic [31:0] mem [32];
    logic [7:0]  q[$];
    logic [7:0]  q2[$];
    int          cyc = 0;
    int          done_cnt = 0, done_cnt2 = 0;
    int          last_xfer = 0, last_xfer2 = 0;
    int          done_edge = 0, done_edge2 = 0;
    int          viol = 0;
    bit          hold_pending = 0;
    logic [7:0]  held = 8'h00;

    register_dump_tx dut (
        .clk(clk), .inicio(inicio), .start(start),
        .rf_addr(rf_addr), .rf_data(rf_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    register_dump_tx #(.NREG(4), .HEADER(8'hA5), .SEND_HEADER(1'b0)) dut2 (
        .clk(clk), .inicio(inicio), .start(start2),
        .rf_addr(rf_addr2), .rf_data(rf_data2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered read port: data appears on the 2nd edge after rf_addr changes.
    always @(posedge clk) begin
        rf_data  <= mem[rf_addr];
        rf_data2 <= mem[rf_addr2];
    end

    // Transfer monitor, done counter and hold-stability observer.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (tx_valid && tx_ready) begin
            q.push_back(tx_data);
            last_xfer = cyc;
        end
        if (tx_valid2 && tx_ready2) begin
            q2.push_back(tx_data2);
            last_xfer2 = cyc;
        end
        if (done) begin
            done_cnt++;
            done_edge = cyc;
        end
        if (done2) begin
            done_cnt2++;
            done_edge2 = cyc;
        end
        if (hold_pending && !inicio && (tx_data !== held || tx_valid !== 1'b1))
            viol++;
        hold_pending = tx_valid && !tx_ready && !inicio;
        held = tx_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] exp_byte(input bit hdr, input int j);
        logic [31:0] w;
        int r, b;
        if (hdr && j == 0) return 8'hA5;
        if (hdr) j = j - 1;
        r = j / 4;
        b = j % 4;
        w = 32'hC0DE0000 | 32'(r);
        return w[31 - 8*b -: 8];
    endfunction

    task automatic check_stream(input string tag, input bit hdr, input int nreg,
                                input logic [7:0] got[$]);
        int bad;
        int n;
        n = 4*nreg + (hdr ? 1 : 0);
        bad = 0;
        check({tag, "_len"}, got.size(), n);
        for (int j = 0; j < got.size() && j < n; j++)
            if (got[j] !== exp_byte(hdr, j)) bad++;
        check({tag, "_bytes_wrong"}, bad, 0);
    endtask

    task automatic wait_done(input int maxc, input bit rnd, output bit ok);
        int target;
        target = done_cnt + 1;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        tx_ready = 1'b1;
    endtask

    initial begin
        int e0;
        int base;
        bit ok;

        for (int k = 0; k < 32; k++) mem[k] = 32'hC0DE0000 | 32'(k);
        inicio = 1'b1; start = 1'b0; start2 = 1'b0;
        tx_ready = 1'b1; tx_ready2 = 1'b1;

        // Reset with random inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start    = 1'($urandom_range(0, 1));
            tx_ready = 1'($urandom_range(0, 1));
        end
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rf_addr", rf_addr, 0);
        @(negedge clk);
        start = 1'b0; tx_ready = 1'b1; inicio = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_tx_valid", tx_valid, 0);
        check("idle_busy", busy, 0);

        // Full dump, tx_ready held high
        q.delete();
        base = done_cnt;
        e0 = cyc + 1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("e0_busy", busy, 1);
        check("e0_tx_valid", tx_valid, 1);
        check("e0_tx_data", tx_data, 8'hA5);
        wait_done(400, 1'b0, ok);
        check("full_timeout_ok", ok, 1);
        check_stream("full", 1'b1, 32, q);
        check("full_done_count", done_cnt - base, 1);
        check("full_last_xfer_cycle", last_xfer - e0, 193);
        check("full_done_cycle", done_edge - e0, 194);
        check("full_rf_addr_end", rf_addr, 31);
        check("full_busy_after", busy, 0);

        // Random backpressure
        q.delete();
        base = done_cnt;
        viol = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2000, 1'b1, ok);
        check("bp_timeout_ok", ok, 1);
        check_stream("bp", 1'b1, 32, q);
        check("bp_hold_violations", viol, 0);
        check("bp_done_count", done_cnt - base, 1);

        // start pulses mid-SEND and in the DONE cycle are ignored
        q.delete();
        base = done_cnt;
        ok = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_cnt > base && !done) begin
                start = 1'b0;
                ok = 1'b1;
                break;
            end
            start = (i == 60) || done;
        end
        start = 1'b0;
        check("ign_timeout_ok", ok, 1);
        repeat (3) @(negedge clk);
        check("ign_busy_after", busy, 0);
        check("ign_len", q.size(), 129);
        check("ign_done_count", done_cnt - base, 1);

        // start in the first IDLE cycle after DONE is accepted
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("acc_see_done", ok, 1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("acc_busy", busy, 1);
        wait_done(400, 1'b0, ok);
        check("acc_timeout_ok", ok, 1);

        // Asynchronous reset during register 7, byte 2
        q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (q.size() == 31) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_reach_r7b2", ok, 1);
        check("mid_tx_data_before", tx_data, 8'h00);
        #2 inicio = 1'b1;
        #1;
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rf_addr", rf_addr, 0);
        @(negedge clk);
        inicio = 1'b0;
        @(negedge clk);
        q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400, 1'b0, ok);
        check("after_rst_timeout_ok", ok, 1);
        check_stream("after_rst", 1'b1, 32, q);

        // No header, 4 registers
        q2.delete();
        base = done_cnt2;
        e0 = cyc + 1;
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        check("small_e0_busy", busy2, 1);
        check("small_e0_tx_valid", tx_valid2, 0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_cnt2 > base) begin
                ok = 1'b1;
                break;
            end
        end
        check("small_timeout_ok", ok, 1);
        check_stream("small", 1'b0, 4, q2);
        check("small_last_xfer_cycle", last_xfer2 - e0, 24);
        check("small_done_cycle", done_edge2 - e0, 25);
        check("small_done_count", done_cnt2 - base, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/register_dump_tx.md
# register_dump_tx

Debug read-out sequencer for the pipeline's register file. On a start pulse it walks register addresses 0..NREG-1 through one register-file read port and captures each 32-bit word. It streams the words MSB-first as bytes over a valid/ready byte interface, optionally prefixed by a header byte. The byte interface feeds the debug UART transmitter, so the host can dump the whole bank without the 32 parallel snapshot buses.

## Interface
- NREG, default 32: number of registers dumped, addresses 0..NREG-1; legal range 1..32.
- HEADER, default 8'hA5: header byte value.
- SEND_HEADER, default 1: 1 = emit HEADER before register data; 0 = no header.

- clk  in  1  system clock; all state changes on its rising edge.
- inicio  in  1  reset; one clock, reset is asynchronous and active-high.
- start  in  1  dump request, sampled only in IDLE.
- rf_addr  out  5  register-file read address, registered.
- rf_data  in  32  register-file read data; valid on the 2nd rising edge after rf_addr changes (registered read port).
- tx_data  out  8  byte to transmit, registered.
- tx_valid  out  1  tx_data holds a byte.
- tx_ready  in  1  sink accepts a byte; transfer = tx_valid && tx_ready at a rising edge.
- busy  out  1  high from start acceptance until DONE ends.
- done  out  1  one-cycle pulse after the last byte transfers.

## Operation
- Reset values: state IDLE, rf_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, index=0, byte count=0. Reset is applied immediately on inicio rise, whether idle or mid-dump, with no partial completion. On inicio fall the block waits for a new start.
- States and transitions:
  - IDLE: on start=1, set busy=1 and index=0. Go to HDR if SEND_HEADER, else REQ. While idle, start=0 keeps the block in IDLE.
  - HDR: tx_valid=1, tx_data=HEADER. On transfer, go to REQ.
  - REQ: rf_addr=index, tx_valid=0. Stay one cycle, then go to CAP.
  - CAP: one cycle. At its exit edge, latch rf_data into a 32-bit shift register, byte count=0, and go to SEND.
  - SEND: tx_valid=1, tx_data=shift[31:24]. On each transfer, shift left 8 and increment byte count.
    - After the 4th transfer with index<NREG-1: index+1, go to REQ.
    - After the 4th transfer with index=NREG-1: go to DONE.
  - DONE: done=1, tx_valid=0 for one cycle. Then go to IDLE with busy=0.
- Handshake rules:
  - While tx_valid=1 and tx_ready=0, tx_data, the state, and the shift register hold unchanged.
  - tx_valid never drops without a transfer, except on reset.
- start is ignored while busy. The inicio and start inputs never act as data.
- Index is 5 bits and never wraps past NREG-1. rf_addr holds its last value outside REQ/CAP.
- Byte order per register: bits 31:24, 23:16, 15:8, 7:0.
- Total bytes per dump = 4*NREG + SEND_HEADER.

## Timing
- Outputs are registered, with no combinational path from tx_ready or start to any output.
- start high at edge e0 (IDLE) → busy=1 and tx_valid=1 (HDR, or REQ with tx_valid=0) from e0.
- Per register with tx_ready held high: REQ 1 + CAP 1 + SEND 4 = 6 cycles.
- Full dump, defaults, tx_ready=1: 1 (header) + 32*6 = 193 cycles from e0 to the last transfer. done is high in cycle 194, and busy falls at the edge ending DONE.
- Each cycle of tx_ready=0 while tx_valid=1 adds exactly one cycle.
- start in the DONE cycle is ignored. start in the first IDLE cycle after DONE is accepted.

## Test plan
- Reset: hold inicio=1 with random inputs → all outputs 0. Release, then stay idle with start=0 → tx_valid=0, busy=0.
- Full dump, tx_ready=1, register k preloaded with 32'hC0DE0000|k:
  - Byte stream is A5, C0, DE, 00, 00, C0, DE, 00, 01, …, C0, DE, 00, 1F.
  - Exactly 129 transfers, done pulses once in cycle 194, and rf_addr sequences 0..31.
- Backpressure: toggle tx_ready pseudo-randomly → identical 129-byte stream, tx_data stable whenever tx_valid && !tx_ready, and no duplicate or dropped bytes.
- start pulses while busy (mid-SEND and during DONE) → ignored: single 129-byte dump and one done pulse.
- Reset mid-operation: assert inicio during SEND of register 7 byte 2 → outputs go to 0 asynchronously. A new start produces a complete dump from the header and register 0.
- SEND_HEADER=0, NREG=4, tx_ready=1 → 16 bytes with no A5, and done in cycle 25 after start.
